// File: rtl/add_rr_scheduler.sv
// rtl/add_rr_scheduler.sv - round-robin front end sharing one signed adder among NREQ requesters
// One transaction at a time: grant in IDLE, drive the adder in ISSUE, hold the tagged sum in RESP.
module add_rr_scheduler #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                adder_en,
  output logic [N-1:0]        adder_a,
  output logic [N-1:0]        adder_b,
  input  logic [N:0]          adder_result,
  input  logic                adder_valid,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N:0]          rsp_data,
  output logic [IDW-1:0]      rsp_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_last;       // last granted requester: both the rr pointer and the response tag
  logic [N-1:0]    r_op_a;
  logic [N-1:0]    r_op_b;
  logic            r_rsp_valid;
  logic [N:0]      r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;

  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt;
  logic            w_accept;
  logic            w_capture;
  logic            w_release;

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_gnt_found && req_valid[idx]) begin
        w_gnt_found = 1'b1;
        w_gnt       = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by rst so no requester sees an accept while the block is held in reset.
        if (w_gnt_found && !rst) begin
          req_ready[w_gnt] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (adder_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= PTR_RST;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_op_a <= req_a[int'(w_gnt)*N +: N];
        r_op_b <= req_b[int'(w_gnt)*N +: N];
        r_last <= w_gnt;
      end
      if (w_capture) begin
        r_rsp_data  <= adder_result;
        r_rsp_id    <= r_last;
        r_rsp_valid <= 1'b1;
      end else if (w_release) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Operand registers only load on a grant, so the adder inputs hold outside ISSUE.
  assign adder_en  = (r_state == S_ISSUE);
  assign adder_a   = r_op_a;
  assign adder_b   = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_add_rr_scheduler.sv
// tb/tb_add_rr_scheduler.sv - scoreboard bench for add_rr_scheduler with a behavioural adder
module tb_add_rr_scheduler;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              adder_en;
  logic [N-1:0]      adder_a;
  logic [N-1:0]      adder_b;
  logic [N:0]        adder_result;
  logic              adder_valid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              av_ok;

  typedef struct {
    logic [IDW-1:0] id;
    logic [N:0]     data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  add_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .adder_en(adder_en), .adder_a(adder_a), .adder_b(adder_b),
    .adder_result(adder_result), .adder_valid(adder_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  assign adder_result = {adder_a[N-1], adder_a} + {adder_b[N-1], adder_b};
  assign adder_valid  = adder_en & av_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*N +: N] = N'(a);
    req_b[i*N +: N] = N'(b);
  endtask

  task automatic push_exp(input int id, input int a, input int b);
    exp_t e;
    e.id   = IDW'(id);
    e.data = (N+1)'(a + b);
    sb.push_back(e);
  endtask

  task automatic wait_grant(output bit to);
    to = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready != '0) begin
        to = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output bit to);
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        to = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== '0 || adder_en !== 1'b0 || adder_a !== '0 || adder_b !== '0 ||
        rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b en=%b a=%h b=%h rv=%b rd=%h rid=%0d, expected all zero",
               req_ready, adder_en, adder_a, adder_b, rsp_valid, rsp_data, rsp_id);
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_no_ready: req_ready=%b expected 0000", req_ready);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    bit   to;
    set_ops(0, 3, 4);
    req_valid = 4'b0001;
    push_exp(0, 3, 4);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001 || adder_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_grant: ready=%b en=%b expected 0001/0", req_ready, adder_en);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (adder_en !== 1'b1 || adder_a !== 4'd3 || adder_b !== 4'd4 || req_ready !== '0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_issue: en=%b a=%0d b=%0d ready=%b rv=%b expected 1/3/4/0000/0",
               adder_en, adder_a, adder_b, req_ready, rsp_valid);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data) begin
      n_bad++;
      $display("FAIL single_rsp: rv=%b id=%0d data=%0d expected 1/%0d/%0d",
               rsp_valid, rsp_id, $signed(rsp_data), e.id, $signed(e.data));
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    bit   to;
    int   ids[2]  = '{2, 1};
    int   opa[2]  = '{-8, 7};
    int   opb[2]  = '{-8, 7};
    for (int t = 0; t < 2; t++) begin
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << ids[t];
      set_ops(ids[t], opa[t], opb[t]);
      req_valid = oh;
      push_exp(ids[t], opa[t], opb[t]);
      wait_grant(to);
      n_cmp++;
      if (to || req_ready !== oh) begin
        n_bad++;
        $display("FAIL ovf_grant: ready=%b expected %b", req_ready, oh);
      end
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(to);
      e = sb.pop_front();
      n_cmp++;
      if (to || rsp_id !== e.id || rsp_data !== e.data) begin
        n_bad++;
        $display("FAIL ovf_rsp: rv=%b id=%0d data=%b expected %0d/%b",
                 rsp_valid, rsp_id, rsp_data, e.id, e.data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_valid;
    exp_t e;
    bit   to;
    int   order[5] = '{0, 1, 2, 3, 0};
    int   opa[4]   = '{3, 7, -8, -5};
    int   opb[4]   = '{4, 7, -8, 2};
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, opa[i], opb[i]);
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) push_exp(order[t], opa[order[t]], opb[order[t]]);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << sb[0].id;
      wait_grant(to);
      n_cmp++;
      if (to || req_ready !== oh) begin
        n_bad++;
        $display("FAIL rr_grant%0d: ready=%b expected %b", t, req_ready, oh);
      end
      @(posedge clk); #1;
      if (t == 4) req_valid = '0;
      wait_rsp(to);
      e = sb.pop_front();
      n_cmp++;
      if (to || rsp_id !== e.id || rsp_data !== e.data) begin
        n_bad++;
        $display("FAIL rr_rsp%0d: rv=%b id=%0d data=%0d expected %0d/%0d",
                 t, rsp_valid, rsp_id, $signed(rsp_data), e.id, $signed(e.data));
      end
    end
  endtask

  task automatic test_back_pressure;
    exp_t e;
    bit   to;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_ops(3, -5, 2);
    set_ops(1, 7, 7);
    req_valid = 4'b1000;
    push_exp(3, -5, 2);
    wait_grant(to);
    n_cmp++;
    if (to || req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL bp_grant: ready=%b expected 1000", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_rsp(to);
    e = sb.pop_front();
    n_cmp++;
    if (to || rsp_id !== e.id || rsp_data !== e.data) begin
      n_bad++;
      $display("FAIL bp_rsp: rv=%b id=%0d data=%0d expected %0d/%0d",
               rsp_valid, rsp_id, $signed(rsp_data), e.id, $signed(e.data));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data || req_ready !== '0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: rv=%b id=%0d data=%0d ready=%b expected 1/%0d/%0d/0000",
                 c, rsp_valid, rsp_id, $signed(rsp_data), req_ready, e.id, $signed(e.data));
      end
    end
    rsp_ready = 1'b1;
    push_exp(1, 7, 7);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_release: rv=%b ready=%b expected 0/0010", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(to);
    e = sb.pop_front();
    n_cmp++;
    if (to || rsp_id !== e.id || rsp_data !== e.data) begin
      n_bad++;
      $display("FAIL bp_next_rsp: rv=%b id=%0d data=%0d expected %0d/%0d",
               rsp_valid, rsp_id, $signed(rsp_data), e.id, $signed(e.data));
    end
  endtask

  task automatic test_adder_stall;
    exp_t       e;
    bit         to;
    logic [N-1:0] ea;
    logic [N-1:0] eb;
    ea = N'(-1);
    eb = N'(-7);
    @(negedge clk);
    av_ok = 1'b0;
    set_ops(0, -1, -7);
    req_valid = 4'b0001;
    push_exp(0, -1, -7);
    wait_grant(to);
    n_cmp++;
    if (to || req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL stall_grant: ready=%b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (adder_en !== 1'b1 || adder_a !== ea || adder_b !== eb || rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_issue%0d: en=%b a=%h b=%h rv=%b expected 1/%h/%h/0",
                 c, adder_en, adder_a, adder_b, rsp_valid, ea, eb);
      end
    end
    av_ok = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data) begin
      n_bad++;
      $display("FAIL stall_rsp: rv=%b id=%0d data=%0d expected 1/%0d/%0d",
               rsp_valid, rsp_id, $signed(rsp_data), e.id, $signed(e.data));
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   to;
    @(negedge clk);
    av_ok = 1'b0;
    set_ops(1, 2, 3);
    req_valid = 4'b0010;
    wait_grant(to);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (to || adder_en !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_issue: en=%b expected 1", adder_en);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || adder_en !== 1'b0 || adder_a !== '0 || adder_b !== '0) begin
      n_bad++;
      $display("FAIL rstmid_clear: rv=%b en=%b a=%h b=%h expected 0/0/0/0",
               rsp_valid, adder_en, adder_a, adder_b);
    end
    set_ops(0, 6, -2);
    set_ops(3, 1, 1);
    req_valid = 4'b1001;
    av_ok = 1'b1;
    push_exp(0, 6, -2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_grant(to);
    n_cmp++;
    if (to || req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL rstmid_prio: ready=%b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(to);
    e = sb.pop_front();
    n_cmp++;
    if (to || rsp_id !== e.id || rsp_data !== e.data) begin
      n_bad++;
      $display("FAIL rstmid_rsp: rv=%b id=%0d data=%0d expected %0d/%0d",
               rsp_valid, rsp_id, $signed(rsp_data), e.id, $signed(e.data));
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    av_ok     = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_all_valid();
    test_back_pressure();
    test_adder_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
